psg_mixer: RTL and testbench

Parametrised, time-multiplexed stereo mixer for PSG-style unsigned channel outputs. It replaces the fixed A/B/C-to-L/R adder network used today on the motherboard. It supports any channel count, for example one PSG or a PSG plus expansion sound chips, with a per-channel 4-bit left/right pan gain and a per-channel mute. It sits between the sound generators and the audio outputs, and produces one registered stereo sample per sample strobe.

---
 rtl/psg_mix_pkg.sv | 33 +++
 rtl/psg_mix_if.sv | 28 ++
 rtl/psg_mix_mac.sv | 38 +++
 rtl/psg_mixer.sv | 164 ++++++++++++++++
 tb/tb_psg_mixer.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/psg_mix_pkg.sv
// Shared types and width/scaling helpers for the PSG stereo mixer.
package psg_mix_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Working width for the scale helper; wide enough for any sane ACC_W/OUT_W.
  localparam int unsigned SCALE_W = 64;

  // Accumulator width that can hold NUM_CH full-scale products without wrapping.
  function automatic int unsigned acc_width(input int unsigned in_w,
                                            input int unsigned gain_w,
                                            input int unsigned num_ch);
    return in_w + gain_w + $clog2(num_ch);
  endfunction

  // Left-align a narrow accumulator into the output, or truncate a wide one.
  function automatic logic [SCALE_W-1:0] scale(input logic [SCALE_W-1:0] acc,
                                               input int unsigned         acc_w,
                                               input int unsigned         out_w);
    logic [SCALE_W-1:0] res;
    if (out_w >= acc_w) begin
      res = acc << (out_w - acc_w);
    end else begin
      res = acc >> (acc_w - out_w);
    end
    return res;
  endfunction

endpackage

// File: rtl/psg_mix_if.sv
// Sample strobe, channel/pan/mute inputs and stereo result bundle of the mixer.
interface psg_mix_if #(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned IN_W   = 8,
  parameter int unsigned GAIN_W = 4,
  parameter int unsigned OUT_W  = 16
);
  logic                     ce;
  logic [NUM_CH*IN_W-1:0]   ch_in;
  logic [NUM_CH*GAIN_W-1:0] pan_l;
  logic [NUM_CH*GAIN_W-1:0] pan_r;
  logic [NUM_CH-1:0]        mute;
  logic [OUT_W-1:0]         out_l;
  logic [OUT_W-1:0]         out_r;
  logic                     out_valid;
  logic                     busy;
  logic                     overrun;

  modport master (
    output ce, ch_in, pan_l, pan_r, mute,
    input  out_l, out_r, out_valid, busy, overrun
  );

  modport slave (
    input  ce, ch_in, pan_l, pan_r, mute,
    output out_l, out_r, out_valid, busy, overrun
  );
endinterface

// File: rtl/psg_mix_mac.sv
// One multiply-accumulate lane: gain product, mute gating, clearable accumulator.
module psg_mix_mac #(
  parameter int unsigned IN_W   = 8,
  parameter int unsigned GAIN_W = 4,
  parameter int unsigned ACC_W  = 14
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              en,
  input  logic [IN_W-1:0]   sample,
  input  logic [GAIN_W-1:0] gain,
  input  logic              mute,
  output logic [ACC_W-1:0]  acc
);
  localparam int unsigned PROD_W = IN_W + GAIN_W;

  logic [PROD_W-1:0] prod_c;

  // Channel contribution; a muted channel adds nothing.
  always_comb begin
    prod_c = PROD_W'(sample) * PROD_W'(gain);
    if (mute) begin
      prod_c = '0;
    end
  end

  // Accumulator: clear on mix start, add one product per ACC cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + ACC_W'(prod_c);
    end
  end
endmodule

// File: rtl/psg_mixer.sv
// Time-multiplexed stereo mixer: one channel per cycle, one stereo sample per ce.
module psg_mixer #(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned IN_W   = 8,
  parameter int unsigned GAIN_W = 4,
  parameter int unsigned OUT_W  = 16
) (
  input logic      clk,
  input logic      reset_n,
  psg_mix_if.slave bus
);
  import psg_mix_pkg::*;

  localparam int unsigned      ACC_W    = acc_width(IN_W, GAIN_W, NUM_CH);
  localparam int unsigned      IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

  state_t                   state;
  state_t                   state_next;
  logic [IDX_W-1:0]         idx;
  logic [IDX_W-1:0]         idx_next;
  logic                     start_c;
  logic                     acc_en_c;
  logic                     done_c;

  logic [NUM_CH*IN_W-1:0]   ch_q;
  logic [NUM_CH*GAIN_W-1:0] pan_l_q;
  logic [NUM_CH*GAIN_W-1:0] pan_r_q;
  logic [NUM_CH-1:0]        mute_q;

  logic [IN_W-1:0]          sel_ch_c;
  logic [GAIN_W-1:0]        sel_pl_c;
  logic [GAIN_W-1:0]        sel_pr_c;
  logic                     sel_mute_c;

  logic [ACC_W-1:0]         acc_l;
  logic [ACC_W-1:0]         acc_r;

  // State and channel index registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  // Sequencing: accept ce in IDLE, walk the channels, then publish.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    start_c    = 1'b0;
    acc_en_c   = 1'b0;
    done_c     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.ce) begin
          start_c    = 1'b1;
          idx_next   = '0;
          state_next = ACC;
        end
      end
      ACC: begin
        acc_en_c = 1'b1;
        if (idx == LAST_IDX) begin
          state_next = DONE;
        end else begin
          idx_next = idx + IDX_W'(1);
        end
      end
      DONE: begin
        done_c     = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Snapshot of all channel inputs so later changes cannot disturb a mix.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ch_q    <= '0;
      pan_l_q <= '0;
      pan_r_q <= '0;
      mute_q  <= '0;
    end else if (start_c) begin
      ch_q    <= bus.ch_in;
      pan_l_q <= bus.pan_l;
      pan_r_q <= bus.pan_r;
      mute_q  <= bus.mute;
    end
  end

  // Channel select for the current index, shared by both lanes.
  always_comb begin
    sel_ch_c   = '0;
    sel_pl_c   = '0;
    sel_pr_c   = '0;
    sel_mute_c = 1'b0;
    for (int k = 0; k < int'(NUM_CH); k++) begin
      if (idx == IDX_W'(k)) begin
        sel_ch_c   = ch_q[k*IN_W +: IN_W];
        sel_pl_c   = pan_l_q[k*GAIN_W +: GAIN_W];
        sel_pr_c   = pan_r_q[k*GAIN_W +: GAIN_W];
        sel_mute_c = mute_q[k];
      end
    end
  end

  psg_mix_mac #(
    .IN_W   (IN_W),
    .GAIN_W (GAIN_W),
    .ACC_W  (ACC_W)
  ) u_mac_l (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (start_c),
    .en      (acc_en_c),
    .sample  (sel_ch_c),
    .gain    (sel_pl_c),
    .mute    (sel_mute_c),
    .acc     (acc_l)
  );

  psg_mix_mac #(
    .IN_W   (IN_W),
    .GAIN_W (GAIN_W),
    .ACC_W  (ACC_W)
  ) u_mac_r (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (start_c),
    .en      (acc_en_c),
    .sample  (sel_ch_c),
    .gain    (sel_pr_c),
    .mute    (sel_mute_c),
    .acc     (acc_r)
  );

  // Registered outputs: scaled sample, valid pulse, busy and sticky overrun.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bus.out_l     <= '0;
      bus.out_r     <= '0;
      bus.out_valid <= 1'b0;
      bus.busy      <= 1'b0;
      bus.overrun   <= 1'b0;
    end else begin
      bus.out_valid <= done_c;
      bus.busy      <= (state_next != IDLE);
      if (done_c) begin
        bus.out_l <= OUT_W'(scale(SCALE_W'(acc_l), ACC_W, OUT_W));
        bus.out_r <= OUT_W'(scale(SCALE_W'(acc_r), ACC_W, OUT_W));
      end
      if (bus.ce && (state != IDLE)) begin
        bus.overrun <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_psg_mixer.sv
// Scoreboard bench for psg_mixer: directed cases on a 3-channel build, random
// mixes on 3-, 1- and 9-channel builds against a sum-and-scale reference.
module tb_psg_mixer;
  localparam int unsigned IN_W   = 8;
  localparam int unsigned GAIN_W = 4;
  localparam int unsigned OUT_W  = 16;
  localparam int unsigned MAXC   = 9;

  typedef struct packed {
    logic [OUT_W-1:0] l;
    logic [OUT_W-1:0] r;
    logic [31:0]      due;
  } exp_t;

  logic        clk      = 1'b0;
  logic        reset_n  = 1'b0;
  int unsigned cyc      = 0;
  int          checks   = 0;
  int          errors   = 0;
  logic        sweep_go = 1'b0;

  exp_t             q0[$];
  exp_t             e0;
  exp_t             m0;
  logic [OUT_W-1:0] last_l = '0;
  logic [OUT_W-1:0] last_r = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  psg_mix_if #(.NUM_CH(3), .IN_W(IN_W), .GAIN_W(GAIN_W), .OUT_W(OUT_W)) bus0 ();
  psg_mixer  #(.NUM_CH(3), .IN_W(IN_W), .GAIN_W(GAIN_W), .OUT_W(OUT_W)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: weighted sums of unmuted channels, then fit the sum to OUT_W.
  function automatic void ref_mix(input int unsigned nc,
                                  input int unsigned ch[MAXC],
                                  input int unsigned pl[MAXC],
                                  input int unsigned pr[MAXC],
                                  input bit [MAXC-1:0] m,
                                  output logic [OUT_W-1:0] l,
                                  output logic [OUT_W-1:0] r);
    int unsigned sl = 0;
    int unsigned sr = 0;
    int unsigned lg = 0;
    int unsigned accw;
    for (int k = 0; k < int'(nc); k++) begin
      if (!m[k]) begin
        sl += ch[k] * pl[k];
        sr += ch[k] * pr[k];
      end
    end
    while ((1 << lg) < nc) lg++;
    accw = IN_W + GAIN_W + lg;
    if (OUT_W >= accw) begin
      l = OUT_W'(sl * (1 << (OUT_W - accw)));
      r = OUT_W'(sr * (1 << (OUT_W - accw)));
    end else begin
      l = OUT_W'(sl / (1 << (accw - OUT_W)));
      r = OUT_W'(sr / (1 << (accw - OUT_W)));
    end
  endfunction

  // Main-DUT monitor: every out_valid must match the oldest expected mix on time.
  always @(negedge clk) begin
    if (bus0.out_valid && q0.size() == 0) begin
      chk("main_unexpected_valid", 32'(bus0.out_valid), 32'd0);
    end else if (bus0.out_valid) begin
      m0 = q0.pop_front();
      chk("main_out_l", 32'(bus0.out_l), 32'(m0.l));
      chk("main_out_r", 32'(bus0.out_r), 32'(m0.r));
      chk("main_latency", cyc, m0.due);
    end else if (q0.size() != 0 && cyc > q0[0].due) begin
      chk("main_missing_valid", 32'(bus0.out_valid), 32'd1);
      void'(q0.pop_front());
    end
  end

  task automatic pulse_ce(input logic [OUT_W-1:0] el, input logic [OUT_W-1:0] er, input bit push);
    bus0.ce = 1'b1;
    if (push) begin
      e0.l   = el;
      e0.r   = er;
      e0.due = cyc + 32'd5;
      q0.push_back(e0);
      last_l = el;
      last_r = er;
    end
    @(negedge clk);
    bus0.ce = 1'b0;
  endtask

  task automatic set_basic();
    bus0.ch_in = {8'hFF, 8'h40, 8'h80};
    bus0.pan_l = {4'd0, 4'd8, 4'd15};
    bus0.pan_r = {4'd15, 4'd8, 4'd0};
    bus0.mute  = 3'b000;
  endtask

  // Parameter sweep: independent random scoreboards for 1 and 9 channels.
  for (genvar g = 0; g < 2; g++) begin : g_sweep
    localparam int unsigned NC = (g == 0) ? 1 : 9;

    psg_mix_if #(.NUM_CH(NC), .IN_W(IN_W), .GAIN_W(GAIN_W), .OUT_W(OUT_W)) sif ();
    psg_mixer  #(.NUM_CH(NC), .IN_W(IN_W), .GAIN_W(GAIN_W), .OUT_W(OUT_W)) u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (sif)
    );

    exp_t             q[$];
    exp_t             e;
    exp_t             me;
    logic             done = 1'b0;
    int unsigned      a[MAXC];
    int unsigned      pl[MAXC];
    int unsigned      pr[MAXC];
    bit [MAXC-1:0]    m;
    logic [OUT_W-1:0] el;
    logic [OUT_W-1:0] er;

    always @(negedge clk) begin
      if (sif.out_valid && q.size() == 0) begin
        chk($sformatf("sw%0d_unexpected_valid", NC), 32'(sif.out_valid), 32'd0);
      end else if (sif.out_valid) begin
        me = q.pop_front();
        chk($sformatf("sw%0d_out_l", NC), 32'(sif.out_l), 32'(me.l));
        chk($sformatf("sw%0d_out_r", NC), 32'(sif.out_r), 32'(me.r));
        chk($sformatf("sw%0d_latency", NC), cyc, me.due);
      end else if (q.size() != 0 && cyc > q[0].due) begin
        chk($sformatf("sw%0d_missing_valid", NC), 32'(sif.out_valid), 32'd1);
        void'(q.pop_front());
      end
    end

    initial begin
      sif.ce    = 1'b0;
      sif.ch_in = '0;
      sif.pan_l = '0;
      sif.pan_r = '0;
      sif.mute  = '0;
      wait (sweep_go);
      @(negedge clk);
      for (int it = 0; it < 25; it++) begin
        for (int k = 0; k < int'(MAXC); k++) begin
          a[k]  = $urandom_range(0, 255);
          pl[k] = $urandom_range(0, 15);
          pr[k] = $urandom_range(0, 15);
          m[k]  = ($urandom_range(0, 3) == 0);
        end
        if (it == 0) begin
          for (int k = 0; k < int'(MAXC); k++) begin
            a[k]  = 255;
            pl[k] = 15;
            pr[k] = 15;
            m[k]  = 1'b0;
          end
        end
        for (int k = 0; k < int'(NC); k++) begin
          sif.ch_in[k*IN_W +: IN_W]     = IN_W'(a[k]);
          sif.pan_l[k*GAIN_W +: GAIN_W] = GAIN_W'(pl[k]);
          sif.pan_r[k*GAIN_W +: GAIN_W] = GAIN_W'(pr[k]);
          sif.mute[k]                   = m[k];
        end
        ref_mix(NC, a, pl, pr, m, el, er);
        e.l   = el;
        e.r   = er;
        e.due = cyc + NC + 32'd2;
        q.push_back(e);
        sif.ce = 1'b1;
        @(negedge clk);
        sif.ce = 1'b0;
        for (int k = 0; k < int'(NC); k++) begin
          sif.ch_in[k*IN_W +: IN_W] = IN_W'($urandom);
        end
        sif.mute = ~sif.mute;
        repeat ($urandom_range(NC + 1, NC + 4)) @(negedge clk);
      end
      repeat (NC + 6) @(negedge clk);
      done = 1'b1;
    end
  end

  initial begin
    int unsigned      a[MAXC];
    int unsigned      pl[MAXC];
    int unsigned      pr[MAXC];
    bit [MAXC-1:0]    m;
    logic [OUT_W-1:0] el;
    logic [OUT_W-1:0] er;
    int               nb;

    bus0.ce    = 1'b0;
    bus0.ch_in = '0;
    bus0.pan_l = '0;
    bus0.pan_r = '0;
    bus0.mute  = '0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_out_l", 32'(bus0.out_l), 32'd0);
    chk("rst_out_r", 32'(bus0.out_r), 32'd0);
    chk("rst_out_valid", 32'(bus0.out_valid), 32'd0);
    chk("rst_busy", 32'(bus0.busy), 32'd0);
    chk("rst_overrun", 32'(bus0.overrun), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Basic mix and busy window
    set_basic();
    pulse_ce(16'h2600, 16'h43C4, 1'b1);
    nb = 0;
    repeat (6) begin
      if (bus0.busy) nb++;
      @(negedge clk);
    end
    chk("basic_busy_cycles", 32'(nb), 32'd4);
    chk("basic_busy_after", 32'(bus0.busy), 32'd0);

    // Full scale
    bus0.ch_in = '1;
    bus0.pan_l = '1;
    bus0.pan_r = '1;
    pulse_ce(16'hB34C, 16'hB34C, 1'b1);
    repeat (6) @(negedge clk);
    chk("full_hold_l", 32'(bus0.out_l), 32'hB34C);

    // Mute and snapshot
    set_basic();
    bus0.mute = 3'b100;
    pulse_ce(16'h2600, 16'h0800, 1'b1);
    bus0.ch_in = '0;
    repeat (6) @(negedge clk);

    // Overrun
    set_basic();
    chk("overrun_before", 32'(bus0.overrun), 32'd0);
    pulse_ce(16'h2600, 16'h43C4, 1'b1);
    @(negedge clk);
    chk("overrun_pre", 32'(bus0.overrun), 32'd0);
    bus0.ce = 1'b1;
    @(negedge clk);
    bus0.ce = 1'b0;
    chk("overrun_set", 32'(bus0.overrun), 32'd1);
    chk("overrun_no_restart_busy", 32'(bus0.busy), 32'd1);
    repeat (2) @(negedge clk);
    chk("overrun_idle_at_valid", 32'(bus0.busy), 32'd0);
    pulse_ce(16'h2600, 16'h43C4, 1'b1);
    chk("overrun_ce_accepted", 32'(bus0.busy), 32'd1);
    repeat (6) @(negedge clk);
    chk("overrun_sticky", 32'(bus0.overrun), 32'd1);

    // Reset mid-mix discards the partial result
    pulse_ce('0, '0, 1'b0);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("rstmid_out_l", 32'(bus0.out_l), 32'd0);
    chk("rstmid_out_r", 32'(bus0.out_r), 32'd0);
    chk("rstmid_out_valid", 32'(bus0.out_valid), 32'd0);
    chk("rstmid_busy", 32'(bus0.busy), 32'd0);
    chk("rstmid_overrun", 32'(bus0.overrun), 32'd0);
    repeat (8) @(negedge clk);
    chk("rstmid_idle", 32'(bus0.busy), 32'd0);

    // Reset beats ce in the same cycle
    reset_n = 1'b0;
    bus0.ce = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    bus0.ce = 1'b0;
    chk("rst_ce_busy", 32'(bus0.busy), 32'd0);
    repeat (6) @(negedge clk);
    pulse_ce(16'h2600, 16'h43C4, 1'b1);
    repeat (6) @(negedge clk);

    // Random mixes at and above the minimum ce spacing
    for (int it = 0; it < 30; it++) begin
      for (int k = 0; k < int'(MAXC); k++) begin
        a[k]  = $urandom_range(0, 255);
        pl[k] = $urandom_range(0, 15);
        pr[k] = $urandom_range(0, 15);
        m[k]  = ($urandom_range(0, 3) == 0);
      end
      for (int k = 0; k < 3; k++) begin
        bus0.ch_in[k*IN_W +: IN_W]     = IN_W'(a[k]);
        bus0.pan_l[k*GAIN_W +: GAIN_W] = GAIN_W'(pl[k]);
        bus0.pan_r[k*GAIN_W +: GAIN_W] = GAIN_W'(pr[k]);
        bus0.mute[k]                   = m[k];
      end
      ref_mix(3, a, pl, pr, m, el, er);
      pulse_ce(el, er, 1'b1);
      bus0.ch_in = 24'($urandom);
      bus0.pan_l = 12'($urandom);
      bus0.mute  = ~bus0.mute;
      repeat ($urandom_range(4, 7)) @(negedge clk);
    end
    repeat (8) @(negedge clk);
    chk("random_no_overrun", 32'(bus0.overrun), 32'd0);

    // Outputs hold while no ce arrives
    repeat (20) @(negedge clk);
    chk("hold_out_l", 32'(bus0.out_l), 32'(last_l));
    chk("hold_out_r", 32'(bus0.out_r), 32'(last_r));

    // Parameter sweep, bounded wait
    sweep_go = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (g_sweep[0].done && g_sweep[1].done) break;
      @(negedge clk);
    end
    chk("sweep_complete", 32'({g_sweep[0].done, g_sweep[1].done}), 32'd3);
    chk("sw1_no_overrun", 32'(g_sweep[0].sif.overrun), 32'd0);
    chk("sw9_no_overrun", 32'(g_sweep[1].sif.overrun), 32'd0);
    chk("queues_drained", 32'(q0.size() + g_sweep[0].q.size() + g_sweep[1].q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
